// File: rtl/sum_pkg.sv
// Shared definitions for the windowed accumulator family: width helpers
// and the default sample/window geometry reused by later windowed blocks.
package sum_pkg;

  // Default geometry of a windowed block: sample width and window depth.
  localparam int SAMPLE_W_DEFAULT = 4;
  localparam int WINDOW_N_DEFAULT = 4;

  // Snapshot of a window's observable state, handy for monitors and
  // for blocks that forward occupancy alongside a result.
  typedef struct packed {
    logic full;
    logic acc;
  } window_flags_t;

  // Width of a sum of n samples of w bits each: n*(2^w-1) never overflows.
  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  // Width of an occupancy counter that must represent 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sum_ignore_window_if.sv
// Sample/result bundle of the windowed accumulator. The master drives the
// strobe, clear and sample; the slave returns sum and occupancy status.
interface sum_ignore_window_if
  import sum_pkg::*;
#(
  parameter int W = SAMPLE_W_DEFAULT,
  parameter int N = WINDOW_N_DEFAULT
);

  localparam int SW = sum_width(W, N);
  localparam int CW = cnt_width(N);

  logic          en;
  logic          clr;
  logic [W-1:0]  d;
  logic [SW-1:0] q;
  logic [CW-1:0] cnt;
  logic          full;
  logic          acc;

  modport master (
    output en, clr, d,
    input  q, cnt, full, acc
  );

  modport slave (
    input  en, clr, d,
    output q, cnt, full, acc
  );

endinterface

// File: rtl/sum_window_shreg.sv
// N-deep sample shift register. Slot 0 takes the new sample, every other
// slot takes its predecessor, and the oldest slot is exposed so the owner
// can subtract it from a running sum. Cleared slots read as zero, which
// lets a partially filled window contribute nothing on eviction.
module sum_window_shreg #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] oldest
);

  logic [W-1:0] slots [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [W-1:0] slot_reg;
      logic [W-1:0] slot_in;

      if (gi == 0) begin : g_head
        assign slot_in = d;
      end else begin : g_body
        assign slot_in = slots[gi-1];
      end

      // One window slot: cleared by reset or clear, loaded on shift.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (clr) begin
          slot_reg <= '0;
        end else if (shift) begin
          slot_reg <= slot_in;
        end
      end

      assign slots[gi] = slot_reg;
    end
  endgenerate

  assign oldest = slots[N-1];

endmodule

// File: rtl/sum_ignore_window.sv
// Sliding-window accumulator: keeps the last N accepted samples and a
// running sum of them. A sample is accepted when strobed and different
// from IGN. The sum is updated incrementally (add new, subtract evicted),
// which stays exact because the sum always equals the slot contents.
module sum_ignore_window
  import sum_pkg::*;
#(
  parameter int           W   = SAMPLE_W_DEFAULT,
  parameter int           N   = WINDOW_N_DEFAULT,
  parameter logic [W-1:0] IGN = '0
) (
  input logic              clk,
  input logic              rst,
  sum_ignore_window_if.slave bus
);

  localparam int SW = sum_width(W, N);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic          accept;
  logic [W-1:0]  oldest;
  logic [SW-1:0] sum_reg;
  logic [SW-1:0] sum_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          full_reg;
  logic          acc_reg;

  // Clear wins over a strobe, so a sample arriving with clr is dropped.
  assign accept = bus.en && (bus.d != IGN) && !bus.clr;

  sum_window_shreg #(
    .W(W),
    .N(N)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .shift (accept),
    .d     (bus.d),
    .oldest(oldest)
  );

  // Next sum and occupancy for an accepted sample; SW bits suffice because
  // the true result is bounded by N*(2^W-1) and wraparound cancels out.
  always_comb begin
    sum_next = sum_reg + SW'(bus.d) - SW'(oldest);
    cnt_next = cnt_reg;
    if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Result and status registers: reset > clear > accept > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= '0;
      cnt_reg  <= '0;
      full_reg <= 1'b0;
      acc_reg  <= 1'b0;
    end else if (bus.clr) begin
      sum_reg  <= '0;
      cnt_reg  <= '0;
      full_reg <= 1'b0;
      acc_reg  <= 1'b0;
    end else if (accept) begin
      sum_reg  <= sum_next;
      cnt_reg  <= cnt_next;
      full_reg <= (cnt_next == CNT_MAX);
      acc_reg  <= 1'b1;
    end else begin
      acc_reg  <= 1'b0;
    end
  end

  assign bus.q    = sum_reg;
  assign bus.cnt  = cnt_reg;
  assign bus.full = full_reg;
  assign bus.acc  = acc_reg;

endmodule

// File: tb/tb_sum_ignore_window.sv
// Bench for sum_ignore_window: four instances with different geometry and
// ignore values, directed tables plus a randomised run against a model
// that recomputes the window sum from scratch every cycle.
module tb_sum_ignore_window;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] cnt;
    logic        full;
    logic        acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  // u0: defaults; u1: IGN=14; u2: W=8 N=3; u3: N=2 with IGN at max value
  sum_ignore_window_if #(.W(4), .N(4)) bus0 ();
  sum_ignore_window_if #(.W(4), .N(4)) bus1 ();
  sum_ignore_window_if #(.W(8), .N(3)) bus2 ();
  sum_ignore_window_if #(.W(4), .N(2)) bus3 ();

  sum_ignore_window #(.W(4), .N(4), .IGN(4'd0))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  sum_ignore_window #(.W(4), .N(4), .IGN(4'd14)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  sum_ignore_window #(.W(8), .N(3), .IGN(8'd0))  u2 (.clk(clk), .rst(rst), .bus(bus2));
  sum_ignore_window #(.W(4), .N(2), .IGN(4'd15)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic exp_t mk(input int q, input int c, input bit f, input bit a);
    exp_t e;
    e.q    = 32'(q);
    e.cnt  = 32'(c);
    e.full = f;
    e.acc  = a;
    return e;
  endfunction

  task automatic test_reset();
    exp_t o0, o1, o2, o3, z;
    #2 rst = 1'b1;
    #1;
    z  = mk(0, 0, 0, 0);
    o0 = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
    o1 = {32'(bus1.q), 32'(bus1.cnt), bus1.full, bus1.acc};
    o2 = {32'(bus2.q), 32'(bus2.cnt), bus2.full, bus2.acc};
    o3 = {32'(bus3.q), 32'(bus3.cnt), bus3.full, bus3.acc};
    checks += 4;
    if (o0 !== z) begin errors++; $display("FAIL reset u0: got q=%0d cnt=%0d full=%0b acc=%0b want all 0", o0.q, o0.cnt, o0.full, o0.acc); end
    if (o1 !== z) begin errors++; $display("FAIL reset u1: got q=%0d cnt=%0d full=%0b acc=%0b want all 0", o1.q, o1.cnt, o1.full, o1.acc); end
    if (o2 !== z) begin errors++; $display("FAIL reset u2: got q=%0d cnt=%0d full=%0b acc=%0b want all 0", o2.q, o2.cnt, o2.full, o2.acc); end
    if (o3 !== z) begin errors++; $display("FAIL reset u3: got q=%0d cnt=%0d full=%0b acc=%0b want all 0", o3.q, o3.cnt, o3.full, o3.acc); end
    $display("txn reset mid-cycle at %0t: outputs sampled", $time);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   d_t [5] = '{7, 0, 3, 2, 9};
    int   q_t [5] = '{7, 7, 10, 12, 21};
    int   c_t [5] = '{1, 1, 2, 3, 4};
    bit   f_t [5] = '{0, 0, 0, 0, 1};
    bit   a_t [5] = '{1, 0, 1, 1, 1};
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus0.en = 1'b1; bus0.clr = 1'b0; bus0.d = 4'(d_t[i]);
      sb.push_back(mk(q_t[i], c_t[i], f_t[i], a_t[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
      checks++;
      $display("txn basic u0 d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b", d_t[i], o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL basic[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
  endtask

  task automatic test_evict_clear();
    // rows: en, clr, d, expected q, cnt, full, acc
    bit   en_t [9] = '{1, 0, 1, 1, 1, 1, 1, 1, 0};
    bit   cl_t [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    int   d_t  [9] = '{15, 5, 5, 6, 1, 1, 1, 1, 3};
    int   q_t  [9] = '{29, 29, 0, 6, 7, 8, 9, 4, 4};
    int   c_t  [9] = '{4, 4, 0, 1, 2, 3, 4, 4, 4};
    bit   f_t  [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
    bit   a_t  [9] = '{1, 0, 0, 1, 1, 1, 1, 1, 0};
    exp_t e, o;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus0.en = en_t[i]; bus0.clr = cl_t[i]; bus0.d = 4'(d_t[i]);
      sb.push_back(mk(q_t[i], c_t[i], f_t[i], a_t[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
      checks++;
      $display("txn evict_clear u0 en=%0b clr=%0b d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b",
               en_t[i], cl_t[i], d_t[i], o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL evict_clear[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
    @(negedge clk);
    bus0.en = 1'b0; bus0.clr = 1'b0;
  endtask

  task automatic test_ignore();
    bit   en_t [6] = '{1, 1, 1, 1, 1, 0};
    int   d_t  [6] = '{14, 7, 14, 3, 0, 7};
    int   q_t  [6] = '{0, 7, 7, 10, 10, 10};
    int   c_t  [6] = '{0, 1, 1, 2, 3, 3};
    bit   a_t  [6] = '{0, 1, 0, 1, 1, 0};
    exp_t e, o;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus1.en = en_t[i]; bus1.clr = 1'b0; bus1.d = 4'(d_t[i]);
      sb.push_back(mk(q_t[i], c_t[i], 1'b0, a_t[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus1.q), 32'(bus1.cnt), bus1.full, bus1.acc};
      checks++;
      $display("txn ignore u1 en=%0b d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b", en_t[i], d_t[i], o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL ignore[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
    @(negedge clk);
    bus1.en = 1'b0;
  endtask

  task automatic test_ign_max();
    int   d_t [5] = '{15, 8, 15, 9, 1};
    int   q_t [5] = '{0, 8, 8, 17, 10};
    int   c_t [5] = '{0, 1, 1, 2, 2};
    bit   f_t [5] = '{0, 0, 0, 1, 1};
    bit   a_t [5] = '{0, 1, 0, 1, 1};
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus3.en = 1'b1; bus3.clr = 1'b0; bus3.d = 4'(d_t[i]);
      sb.push_back(mk(q_t[i], c_t[i], f_t[i], a_t[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus3.q), 32'(bus3.cnt), bus3.full, bus3.acc};
      checks++;
      $display("txn ign_max u3 d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b", d_t[i], o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL ign_max[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
    @(negedge clk);
    bus3.en = 1'b0;
  endtask

  task automatic test_wide();
    int   d_t [5] = '{255, 255, 255, 255, 0};
    int   q_t [5] = '{255, 510, 765, 765, 765};
    int   c_t [5] = '{1, 2, 3, 3, 3};
    bit   f_t [5] = '{0, 0, 1, 1, 1};
    bit   a_t [5] = '{1, 1, 1, 1, 0};
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.en = 1'b1; bus2.clr = 1'b0; bus2.d = 8'(d_t[i]);
      sb.push_back(mk(q_t[i], c_t[i], f_t[i], a_t[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus2.q), 32'(bus2.cnt), bus2.full, bus2.acc};
      checks++;
      $display("txn wide u2 d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b", d_t[i], o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL wide[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
    @(negedge clk);
    bus2.en = 1'b0;
  endtask

  task automatic test_async_reset_mid();
    exp_t e, o;
    @(posedge clk); #2;
    checks++;
    if (bus0.full !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_full: got %0b want 1", bus0.full);
    end
    rst = 1'b1;
    #1;
    o = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
    checks++;
    $display("txn async_reset u0 between edges -> q=%0d cnt=%0d full=%0b acc=%0b", o.q, o.cnt, o.full, o.acc);
    if (o !== mk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL async_reset: got q=%0d cnt=%0d full=%0b acc=%0b want all 0", o.q, o.cnt, o.full, o.acc);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    bus0.en = 1'b1; bus0.clr = 1'b0; bus0.d = 4'd4;
    sb.push_back(mk(4, 1, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front();
    o = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
    checks++;
    $display("txn post_reset u0 d=4 -> q=%0d cnt=%0d full=%0b acc=%0b", o.q, o.cnt, o.full, o.acc);
    if (o !== e) begin
      errors++;
      $display("FAIL post_reset: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
               o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
    end
  endtask

  task automatic test_random();
    int   win [4] = '{0, 0, 0, 0};
    int   mcnt = 0;
    int   msum;
    bit   men, mclr, macc;
    int   md;
    exp_t e, o;
    for (int i = 0; i < 200; i++) begin
      men  = ($urandom_range(0, 3) != 0);
      mclr = (i == 0) || ($urandom_range(0, 31) == 0);
      md   = (i % 17 == 5) ? 15 : int'($urandom_range(0, 15));
      @(negedge clk);
      bus0.en = men; bus0.clr = mclr; bus0.d = 4'(md);
      macc = 1'b0;
      if (mclr) begin
        for (int k = 0; k < 4; k++) win[k] = 0;
        mcnt = 0;
      end else if (men && md != 0) begin
        for (int k = 3; k > 0; k--) win[k] = win[k-1];
        win[0] = md;
        if (mcnt < 4) mcnt++;
        macc = 1'b1;
      end
      msum = 0;
      for (int k = 0; k < 4; k++) msum += win[k];
      sb.push_back(mk(msum, mcnt, mcnt == 4, macc));
      @(posedge clk); #1;
      e = sb.pop_front();
      o = {32'(bus0.q), 32'(bus0.cnt), bus0.full, bus0.acc};
      checks++;
      $display("txn random[%0d] u0 en=%0b clr=%0b d=%0d -> q=%0d cnt=%0d full=%0b acc=%0b",
               i, men, mclr, md, o.q, o.cnt, o.full, o.acc);
      if (o !== e) begin
        errors++;
        $display("FAIL random[%0d]: got q=%0d cnt=%0d full=%0b acc=%0b want q=%0d cnt=%0d full=%0b acc=%0b",
                 i, o.q, o.cnt, o.full, o.acc, e.q, e.cnt, e.full, e.acc);
      end
    end
    @(negedge clk);
    bus0.en = 1'b0; bus0.clr = 1'b0;
  endtask

  initial begin
    bus0.en = 1'b0; bus0.clr = 1'b0; bus0.d = '0;
    bus1.en = 1'b0; bus1.clr = 1'b0; bus1.d = '0;
    bus2.en = 1'b0; bus2.clr = 1'b0; bus2.d = '0;
    bus3.en = 1'b0; bus3.clr = 1'b0; bus3.d = '0;
    test_reset();
    test_basic();
    test_evict_clear();
    test_ignore();
    test_ign_max();
    test_wide();
    test_async_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
